// File: rtl/crop_streamer.sv
// Crops an OUT_ROWS x OUT_COLS window from a raster-order IN_ROWS x IN_COLS pixel stream.
// Optional m_axis_tlast output enabled by defining CROP_STREAMER_TLAST_EN.
module crop_streamer #(
    parameter int IN_ROWS  = 64,
    parameter int IN_COLS  = 64,
    parameter int OUT_ROWS = 10,
    parameter int OUT_COLS = 10
) (
    input  logic                       clk,
    input  logic                       s_axis_resetn,
    input  logic                       ap_start,
    output logic                       ap_ready,
    output logic                       ap_done,
    input  logic [$clog2(IN_ROWS)-1:0] row_offset,
    input  logic [$clog2(IN_COLS)-1:0] col_offset,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [7:0]                 s_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [7:0]                 m_axis_tdata
`ifdef CROP_STREAMER_TLAST_EN
    ,
    output logic                       m_axis_tlast
`endif
);

    // state    | meaning
    // IDLE     | waiting for ap_start, ap_ready high
    // CROPPING | consuming the input frame
    // DRAIN    | input done, waiting for output register to empty
    // DONE     | one-cycle ap_done pulse
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] CROPPING = 2'd1;
    localparam logic [1:0] DRAIN    = 2'd2;
    localparam logic [1:0] DONE     = 2'd3;

    localparam int RW   = $clog2(IN_ROWS);
    localparam int CW   = $clog2(IN_COLS);
    localparam int NPIX = OUT_ROWS * OUT_COLS;
    localparam int NW   = $clog2(NPIX + 1);

    localparam logic [RW-1:0] ROW_OFF_MAX = RW'(IN_ROWS - OUT_ROWS);
    localparam logic [CW-1:0] COL_OFF_MAX = CW'(IN_COLS - OUT_COLS);
    localparam logic [RW-1:0] ROW_LAST    = RW'(IN_ROWS - 1);
    localparam logic [CW-1:0] COL_LAST    = CW'(IN_COLS - 1);
    localparam logic [RW:0]   ROW_SPAN    = (RW+1)'(OUT_ROWS);
    localparam logic [CW:0]   COL_SPAN    = (CW+1)'(OUT_COLS);

    logic [1:0]    state;
    logic [RW-1:0] row;
    logic [RW-1:0] row_off;
    logic [CW-1:0] col;
    logic [CW-1:0] col_off;
    logic [NW-1:0] out_count;
    logic          s_beat;
    logic          in_win;
    logic          load;
    logic          frame_end;

    assign ap_ready      = (state == IDLE);
    assign ap_done       = (state == DONE);
    assign s_axis_tready = (state == CROPPING) && (!m_axis_tvalid || m_axis_tready);
    assign s_beat        = s_axis_tvalid && s_axis_tready;

    // widened compares so row_off + OUT_ROWS cannot overflow at the frame edge
    assign in_win = (row >= row_off) && ({1'b0, row} < ({1'b0, row_off} + ROW_SPAN)) &&
                    (col >= col_off) && ({1'b0, col} < ({1'b0, col_off} + COL_SPAN));
    assign load      = s_beat && in_win;
    assign frame_end = (row == ROW_LAST) && (col == COL_LAST);

    always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) begin
            state   <= IDLE;
            row     <= '0;
            col     <= '0;
            row_off <= '0;
            col_off <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ap_start) begin
                        row_off <= (row_offset > ROW_OFF_MAX) ? ROW_OFF_MAX : row_offset;
                        col_off <= (col_offset > COL_OFF_MAX) ? COL_OFF_MAX : col_offset;
                        row     <= '0;
                        col     <= '0;
                        state   <= CROPPING;
                    end
                end
                CROPPING: begin
                    if (s_beat) begin
                        if (col == COL_LAST) begin
                            col <= '0;
                            row <= row + RW'(1);
                        end else begin
                            col <= col + CW'(1);
                        end
                        if (frame_end) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!m_axis_tvalid || m_axis_tready) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
        end else if (load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= s_axis_tdata;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // counts pixels handed to the output register; reaches NPIX by the end of a frame
    always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) begin
            out_count <= '0;
        end else if ((state == IDLE) && ap_start) begin
            out_count <= '0;
        end else if (load) begin
            out_count <= out_count + NW'(1);
        end
    end

`ifdef CROP_STREAMER_TLAST_EN
    always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) begin
            m_axis_tlast <= 1'b0;
        end else if (load) begin
            m_axis_tlast <= (out_count == NW'(NPIX - 1));
        end else if (m_axis_tready) begin
            m_axis_tlast <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_crop_streamer.sv
// Directed bench for crop_streamer on an 8x8 frame with a 4x4 window.
module tb_crop_streamer;

    localparam int IR = 8;
    localparam int IC = 8;
    localparam int WR = 4;
    localparam int WC = 4;

    logic       clk = 1'b0;
    logic       s_axis_resetn;
    logic       ap_start;
    logic       ap_ready;
    logic       ap_done;
    logic [2:0] row_offset;
    logic [2:0] col_offset;
    logic       s_axis_tvalid;
    logic       s_axis_tready;
    logic [7:0] s_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic [7:0] m_axis_tdata;
`ifdef CROP_STREAMER_TLAST_EN
    logic       m_axis_tlast;
`endif

    int checks = 0;
    int errors = 0;
    int got_q[$];
    int exp_q[$];
    int done_cnt;
    int done_cyc;
    int last_beat_cyc;
    bit hold_bad;
    bit tready_bad;
    bit ready_bad;
    bit tlast_bad;

    always #5 clk = ~clk;

    crop_streamer #(
        .IN_ROWS (IR),
        .IN_COLS (IC),
        .OUT_ROWS(WR),
        .OUT_COLS(WC)
    ) dut (
        .clk          (clk),
        .s_axis_resetn(s_axis_resetn),
        .ap_start     (ap_start),
        .ap_ready     (ap_ready),
        .ap_done      (ap_done),
        .row_offset   (row_offset),
        .col_offset   (col_offset),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tdata (s_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata)
`ifdef CROP_STREAMER_TLAST_EN
        ,
        .m_axis_tlast (m_axis_tlast)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic build_exp(input int ro, input int co);
        int r0;
        int c0;
        r0 = (ro > IR - WR) ? IR - WR : ro;
        c0 = (co > IC - WC) ? IC - WC : co;
        exp_q.delete();
        for (int r = r0; r < r0 + WR; r++)
            for (int c = c0; c < c0 + WC; c++)
                exp_q.push_back(r * IC + c);
    endtask

    // Runs one frame; pixel value equals its raster index (row*8+col).
    task automatic run_frame(input int ro, input int co, input bit bp, input bit mid_start,
                             input int abort_at);
        int idx;
        int cyc;
        bit prev_hold;
        logic [7:0] prev_data;
        got_q.delete();
        done_cnt = 0;
        done_cyc = -1;
        last_beat_cyc = -1;
        hold_bad = 0;
        tready_bad = 0;
        ready_bad = 0;
        tlast_bad = 0;
        build_exp(ro, co);
        @(negedge clk);
        row_offset = 3'(ro);
        col_offset = 3'(co);
        ap_start = 1'b1;
        #1;
        check("ready_before_start", ap_ready, 1);
        @(posedge clk);
        #1;
        ap_start   = 1'b0;
        row_offset = 3'd0;
        col_offset = 3'd0;
        idx = 0;
        cyc = 0;
        prev_hold = 0;
        prev_data = '0;
        while (cyc < 400) begin
            @(negedge clk);
            s_axis_tvalid = (idx < IR * IC) && !(abort_at >= 0 && idx >= abort_at);
            s_axis_tdata  = 8'(idx);
            m_axis_tready = bp ? (cyc % 3 == 0) : 1'b1;
            ap_start      = mid_start && (cyc == 10);
            #1;
            if (prev_hold && (!m_axis_tvalid || m_axis_tdata != prev_data)) hold_bad = 1;
            if (m_axis_tvalid && !m_axis_tready && s_axis_tready) tready_bad = 1;
            if (done_cnt == 0 && ap_ready) ready_bad = 1;
`ifdef CROP_STREAMER_TLAST_EN
            if (m_axis_tlast !== (m_axis_tvalid && (int'(m_axis_tdata) == exp_q[$]))) tlast_bad = 1;
`endif
            if (m_axis_tvalid && m_axis_tready) got_q.push_back(int'(m_axis_tdata));
            if (ap_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_hold = m_axis_tvalid && !m_axis_tready;
            prev_data = m_axis_tdata;
            if (s_axis_tvalid && s_axis_tready) begin
                idx++;
                if (idx == IR * IC) last_beat_cyc = cyc;
            end
            cyc++;
            if (abort_at >= 0 && idx >= abort_at) break;
            if (done_cnt > 0 && cyc > done_cyc + 3) break;
        end
        ap_start = 1'b0;
        s_axis_tvalid = 1'b0;
        if (abort_at < 0) begin
            check("done_pulse_count", done_cnt, 1);
            check("done_latency", (done_cyc - last_beat_cyc >= 1) && (done_cyc - last_beat_cyc <= 3), 1);
            check("pixel_count", got_q.size(), WR * WC);
            for (int i = 0; i < exp_q.size(); i++)
                check("pixel_value", (i < got_q.size()) ? got_q[i] : -1, exp_q[i]);
            check("hold_stable", hold_bad, 0);
            check("tready_backpressure", tready_bad, 0);
            check("ready_low_while_busy", ready_bad, 0);
`ifdef CROP_STREAMER_TLAST_EN
            check("tlast_final_only", tlast_bad, 0);
`endif
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_ap_ready", ap_ready, 1);
        check("rst_ap_done", ap_done, 0);
        check("rst_m_tvalid", m_axis_tvalid, 0);
        check("rst_m_tdata", m_axis_tdata, 0);
        check("rst_s_tready", s_axis_tready, 0);
`ifdef CROP_STREAMER_TLAST_EN
        check("rst_m_tlast", m_axis_tlast, 0);
`endif
    endtask

    initial begin
        s_axis_resetn = 1'b0;
        ap_start      = 1'b0;
        row_offset    = '0;
        col_offset    = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs();
        s_axis_resetn = 1'b1;

        // plain crop, offsets (2,3)
        run_frame(2, 3, 1'b0, 1'b0, -1);
        check("first_pixel_23", got_q.size() > 0 ? got_q[0] : -1, 19);
        check("last_pixel_23", got_q.size() > 0 ? got_q[$] : -1, 46);

        // downstream ready 1 of 3 cycles
        run_frame(2, 3, 1'b1, 1'b0, -1);
        check("bp_first_pixel", got_q.size() > 0 ? got_q[0] : -1, 19);
        check("bp_last_pixel", got_q.size() > 0 ? got_q[$] : -1, 46);

        // offsets beyond the limit clamp to (4,4)
        run_frame(6, 6, 1'b0, 1'b0, -1);
        check("clamp_first_pixel", got_q.size() > 0 ? got_q[0] : -1, 36);
        check("clamp_last_pixel", got_q.size() > 0 ? got_q[$] : -1, 63);

        // ap_start with offsets (0,0) mid-frame is ignored
        run_frame(2, 3, 1'b0, 1'b1, -1);
        check("midstart_first_pixel", got_q.size() > 0 ? got_q[0] : -1, 19);
        check("midstart_last_pixel", got_q.size() > 0 ? got_q[$] : -1, 46);

        // reset after 20 input beats, then a fresh frame
        run_frame(2, 3, 1'b0, 1'b0, 20);
        @(negedge clk);
        s_axis_resetn = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        s_axis_resetn = 1'b1;
        run_frame(2, 3, 1'b0, 1'b0, -1);
        check("post_reset_first_pixel", got_q.size() > 0 ? got_q[0] : -1, 19);
        check("post_reset_last_pixel", got_q.size() > 0 ? got_q[$] : -1, 46);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
